// File: rtl/alu_op_decode_stage_if.sv
// Upstream/downstream handshake and data bundle for the ALU decode stage.
// master = the surrounding pipeline, slave = alu_op_decode_stage.
interface alu_op_decode_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4
);
    logic                  i_flush;
    logic                  i_valid;
    logic                  o_ready;
    logic [31:0]           i_instr;
    logic [DATA_WIDTH-1:0] i_pc;
    logic [DATA_WIDTH-1:0] i_rs1_data;
    logic [DATA_WIDTH-1:0] i_rs2_data;
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_src_a;
    logic [DATA_WIDTH-1:0] o_src_b;
    logic [SEL_WIDTH-1:0]  o_alu_sel;
    logic [4:0]            o_rd;
    logic                  o_reg_write;
    logic                  o_illegal;

    modport master (
        output i_flush, i_valid, i_instr, i_pc, i_rs1_data, i_rs2_data, i_ready,
        input  o_ready, o_valid, o_src_a, o_src_b, o_alu_sel, o_rd, o_reg_write, o_illegal
    );

    modport slave (
        input  i_flush, i_valid, i_instr, i_pc, i_rs1_data, i_rs2_data, i_ready,
        output o_ready, o_valid, o_src_a, o_src_b, o_alu_sel, o_rd, o_reg_write, o_illegal
    );
endinterface

// File: rtl/alu_op_decode_stage.sv
// ID->EX stage: decodes RV32I OP/OP-IMM/LUI/AUIPC into ALU operands and select, behind a 2-entry skid buffer.
// Optional macro ALU_DECODE_RD0_SUPPRESS_EN: clear o_reg_write whenever rd == x0.
module alu_op_decode_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    alu_op_decode_stage_if.slave bus
);
    typedef enum logic [SEL_WIDTH-1:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_SLT  = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001
    } alu_sel_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] src_a;
        logic [DATA_WIDTH-1:0] src_b;
        alu_sel_e              sel;
        logic [4:0]            rd;
        logic                  reg_write;
        logic                  illegal;
    } bundle_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [DATA_WIDTH-1:0] imm_i;
    logic [DATA_WIDTH-1:0] imm_u;
    logic [DATA_WIDTH-1:0] shamt;
    bundle_t               dec;

    assign opcode = bus.i_instr[6:0];
    assign funct3 = bus.i_instr[14:12];
    assign funct7 = bus.i_instr[31:25];
    assign imm_i  = {{20{bus.i_instr[31]}}, bus.i_instr[31:20]};
    assign imm_u  = {bus.i_instr[31:12], 12'b0};
    assign shamt  = {27'b0, bus.i_instr[24:20]};

    // NOTE: every field gets a default before the case tree so no path can infer a latch.
    always_comb begin
        dec           = '0;
        dec.src_a     = bus.i_rs1_data;
        dec.src_b     = bus.i_rs2_data;
        dec.sel       = ALU_ADD;
        dec.rd        = bus.i_instr[11:7];
        dec.illegal   = 1'b0;
        dec.reg_write = 1'b0;

        unique case (opcode)
            OPC_OP: begin
                if (funct7 == F7_ZERO) begin
                    unique case (funct3)
                        3'b000: dec.sel = ALU_ADD;
                        3'b001: dec.sel = ALU_SLL;
                        3'b010: dec.sel = ALU_SLT;
                        3'b011: dec.sel = ALU_SLTU;
                        3'b100: dec.sel = ALU_XOR;
                        3'b101: dec.sel = ALU_SRL;
                        3'b110: dec.sel = ALU_OR;
                        3'b111: dec.sel = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec.sel = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec.sel = ALU_SRA;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec.src_b = imm_i;
                unique case (funct3)
                    3'b000: dec.sel = ALU_ADD;
                    3'b010: dec.sel = ALU_SLT;
                    3'b011: dec.sel = ALU_SLTU;  // immediate already sign-extended; ALU compares unsigned
                    3'b100: dec.sel = ALU_XOR;
                    3'b110: dec.sel = ALU_OR;
                    3'b111: dec.sel = ALU_AND;
                    3'b001: begin
                        dec.src_b   = shamt;
                        dec.sel     = ALU_SLL;
                        dec.illegal = (funct7 != F7_ZERO);
                    end
                    3'b101: begin
                        dec.src_b   = shamt;
                        dec.sel     = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        dec.illegal = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
                    end
                endcase
            end
            OPC_LUI: begin
                dec.src_a = '0;
                dec.src_b = imm_u;
            end
            OPC_AUIPC: begin
                dec.src_a = bus.i_pc;
                dec.src_b = imm_u;
            end
            default: dec.illegal = 1'b1;
        endcase

        // Illegal bundles still travel downstream, but as a harmless ADD of rs1/rs2 with no writeback.
        if (dec.illegal) begin
            dec.src_a = bus.i_rs1_data;
            dec.src_b = bus.i_rs2_data;
            dec.sel   = ALU_ADD;
        end
`ifdef ALU_DECODE_RD0_SUPPRESS_EN
        dec.reg_write = !dec.illegal && (dec.rd != 5'd0);
`else
        dec.reg_write = !dec.illegal;
`endif
    end

    logic    out_valid;
    logic    skid_valid;
    bundle_t out_q;
    bundle_t skid_q;
    logic    accept;
    logic    out_free;

    assign accept   = bus.i_valid && !skid_valid;
    assign out_free = !out_valid || bus.i_ready;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: both bundle registers are reset too, so data outputs read 0 straight out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else if (bus.i_flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            // skid holds the older bundle, so it drains ahead of any new input
            if (skid_valid) begin
                out_q      <= skid_q;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_q     <= dec;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end

    assign bus.o_ready     = !skid_valid;
    assign bus.o_valid     = out_valid;
    assign bus.o_src_a     = out_q.src_a;
    assign bus.o_src_b     = out_q.src_b;
    assign bus.o_alu_sel   = out_q.sel;
    assign bus.o_rd        = out_q.rd;
    assign bus.o_reg_write = out_q.reg_write;
    assign bus.o_illegal   = out_q.illegal;
endmodule

// File: tb/tb_alu_op_decode_stage.sv
// Self-checking bench for alu_op_decode_stage: vector table streamed through a scoreboard,
// plus directed backpressure, flush and async-reset sequences.
module tb_alu_op_decode_stage;
    typedef struct packed {
        logic [31:0] src_a;
        logic [31:0] src_b;
        logic [3:0]  sel;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } bundle_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        bundle_t     exp;
    } vec_t;

    logic clk;
    logic rst_n;

    alu_op_decode_stage_if #(.DATA_WIDTH(32), .SEL_WIDTH(4)) bus ();

    alu_op_decode_stage #(.DATA_WIDTH(32), .SEL_WIDTH(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t    vecs[$];
    bundle_t sb[$];
    bundle_t cur_exp;
    int      total;
    int      bad;

`ifdef ALU_DECODE_RD0_SUPPRESS_EN
    localparam logic RD0_RW = 1'b0;
`else
    localparam logic RD0_RW = 1'b1;
`endif

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bundle_t dut_out();
        bundle_t b;
        b.src_a = bus.o_src_a;
        b.src_b = bus.o_src_b;
        b.sel   = bus.o_alu_sel;
        b.rd    = bus.o_rd;
        b.rw    = bus.o_reg_write;
        b.ill   = bus.o_illegal;
        return b;
    endfunction

    task automatic add_vec(input string name, input logic [31:0] instr, input logic [31:0] pc,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] ea, input logic [31:0] eb, input logic [3:0] esel,
                           input logic [4:0] erd, input logic erw, input logic eill);
        vec_t v;
        v.name  = name;
        v.instr = instr;
        v.pc    = pc;
        v.rs1   = rs1;
        v.rs2   = rs2;
        v.exp   = '{src_a: ea, src_b: eb, sel: esel, rd: erd, rw: erw, ill: eill};
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        bus.i_valid    = 1'b1;
        bus.i_instr    = v.instr;
        bus.i_pc       = v.pc;
        bus.i_rs1_data = v.rs1;
        bus.i_rs2_data = v.rs2;
        cur_exp        = v.exp;
    endtask

    task automatic idle();
        bus.i_valid = 1'b0;
    endtask

    // One clock: score the handshakes seen at the falling edge, then step past the rising edge.
    task automatic cycle(output logic accepted);
        bundle_t exp_b;
        @(negedge clk);
        accepted = 1'b0;
        if (bus.o_valid && bus.i_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_output: got %h expected nothing", dut_out());
            end else begin
                exp_b = sb.pop_front();
                check("bundle", dut_out(), exp_b);
            end
        end
        if (bus.i_valid && bus.o_ready && !bus.i_flush) begin
            sb.push_back(cur_exp);
            accepted = 1'b1;
        end
        if (bus.i_flush) sb.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        logic acc;
        idle();
        bus.i_ready = 1'b1;
        for (int k = 0; k < 10 && sb.size() != 0; k++) cycle(acc);
        cycle(acc);
        cycle(acc);
        check(name, sb.size(), 0);
    endtask

    initial begin
        logic acc;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.i_flush    = 1'b0;
        bus.i_valid    = 1'b0;
        bus.i_ready    = 1'b1;
        bus.i_instr    = '0;
        bus.i_pc       = '0;
        bus.i_rs1_data = '0;
        bus.i_rs2_data = '0;
        cur_exp        = '0;

        //        name        instr         pc            rs1           rs2           src_a         src_b         sel    rd  rw      ill
        add_vec("add",      32'h002081B3, 32'h0,        32'd5,        32'd7,        32'd5,        32'd7,        4'h0, 3,  1'b1,   1'b0);
        add_vec("srai",     32'h40435293, 32'h0,        32'h80000000, 32'd9,        32'h80000000, 32'd4,        4'h7, 5,  1'b1,   1'b0);
        add_vec("sltiu_m1", 32'hFFF13093, 32'h0,        32'h10,       32'h22,       32'h10,       32'hFFFFFFFF, 4'h3, 1,  1'b1,   1'b0);
        add_vec("auipc",    32'h12345097, 32'h100,      32'h55,       32'h66,       32'h100,      32'h12345000, 4'h0, 1,  1'b1,   1'b0);
        add_vec("lui",      32'hABCDE3B7, 32'h200,      32'h77,       32'h88,       32'h0,        32'hABCDE000, 4'h0, 7,  1'b1,   1'b0);
        add_vec("sub",      32'h40628233, 32'h0,        32'd10,       32'd3,        32'd10,       32'd3,        4'h1, 4,  1'b1,   1'b0);
        add_vec("ill_f7",   32'h4062F233, 32'h0,        32'hAA,       32'hBB,       32'hAA,       32'hBB,       4'h0, 4,  1'b0,   1'b1);
        add_vec("ill_load", 32'h00012083, 32'h0,        32'hCC,       32'hDD,       32'hCC,       32'hDD,       4'h0, 1,  1'b0,   1'b1);
        add_vec("nop",      32'h00000013, 32'h0,        32'h11,       32'h12,       32'h11,       32'h0,        4'h0, 0,  RD0_RW, 1'b0);
        add_vec("slli31",   32'h01F19113, 32'h0,        32'h3,        32'h4,        32'h3,        32'd31,       4'h2, 2,  1'b1,   1'b0);
        add_vec("ill_slli", 32'h41F19113, 32'h0,        32'h3,        32'h4,        32'h3,        32'h4,        4'h0, 2,  1'b0,   1'b1);
        add_vec("xori_neg", 32'h8004C413, 32'h0,        32'h9,        32'h1,        32'h9,        32'hFFFFF800, 4'h5, 8,  1'b1,   1'b0);
        add_vec("sra",      32'h403150B3, 32'h0,        32'h2,        32'h3,        32'h2,        32'h3,        4'h7, 1,  1'b1,   1'b0);
        add_vec("and",      32'h003170B3, 32'h0,        32'hF0,       32'h3C,       32'hF0,       32'h3C,       4'h9, 1,  1'b1,   1'b0);
        add_vec("or",       32'h003160B3, 32'h0,        32'h1,        32'h2,        32'h1,        32'h2,        4'h8, 1,  1'b1,   1'b0);
        add_vec("slt",      32'h003120B3, 32'h0,        32'h5,        32'h6,        32'h5,        32'h6,        4'h4, 1,  1'b1,   1'b0);
        add_vec("srli",     32'h00715093, 32'h0,        32'h40,       32'h41,       32'h40,       32'd7,        4'h6, 1,  1'b1,   1'b0);
        add_vec("ill_mul",  32'h023100B3, 32'h0,        32'h7,        32'h8,        32'h7,        32'h8,        4'h0, 1,  1'b0,   1'b1);

        // Async reset values before any clock edge
        #2;
        check("reset_valid", bus.o_valid, 1'b0);
        check("reset_ready", bus.o_ready, 1'b1);
        check("reset_data", dut_out(), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back stream with i_ready=1: output must stay valid every cycle (no bubbles)
        foreach (vecs[i]) begin
            drive(vecs[i]);
            cycle(acc);
            check({"stream_valid_", vecs[i].name}, bus.o_valid, 1'b1);
        end
        drain("stream_drained");

        // Backpressure: A to output, B to skid, C held off
        bus.i_ready = 1'b0;
        drive(vecs[0]);
        cycle(acc);
        drive(vecs[1]);
        cycle(acc);
        check("bp_ready_low", bus.o_ready, 1'b0);
        check("bp_out_is_a", dut_out(), vecs[0].exp);
        drive(vecs[2]);
        cycle(acc);
        cycle(acc);
        check("bp_still_full", bus.o_ready, 1'b0);
        check("bp_valid_held", bus.o_valid, 1'b1);
        check("bp_out_stable", dut_out(), vecs[0].exp);
        bus.i_ready = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 10 && !acc; k++) cycle(acc);
        check("bp_c_accepted", acc, 1'b1);
        drain("bp_drained");

        // Flush with output and skid both full; the flush-cycle input must vanish
        bus.i_ready = 1'b0;
        drive(vecs[3]);
        cycle(acc);
        drive(vecs[4]);
        cycle(acc);
        check("fl_full", bus.o_ready, 1'b0);
        drive(vecs[5]);
        bus.i_flush = 1'b1;
        cycle(acc);
        bus.i_flush = 1'b0;
        idle();
        check("fl_valid_low", bus.o_valid, 1'b0);
        check("fl_ready_high", bus.o_ready, 1'b1);
        bus.i_ready = 1'b1;
        repeat (3) cycle(acc);
        drive(vecs[9]);
        cycle(acc);
        drain("fl_drained");

        // Reset asserted mid-stream, away from any clock edge
        bus.i_ready = 1'b0;
        drive(vecs[0]);
        cycle(acc);
        drive(vecs[1]);
        cycle(acc);
        rst_n = 1'b0;
        #1;
        check("rst_valid_low", bus.o_valid, 1'b0);
        check("rst_ready_high", bus.o_ready, 1'b1);
        check("rst_data_zero", dut_out(), '0);
        sb.delete();
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.i_ready = 1'b1;
        repeat (3) cycle(acc);
        drive(vecs[11]);
        cycle(acc);
        drain("rst_drained");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
